// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C register-write target.
//   state_t       : protocol state of the target FSM (also exported for debug)
//   DEV_ADDR_DEF  : default 7-bit device address (write byte 8'h42)
//   BYTE_W        : data/address byte width
//   BITCNT_W      : width of the per-byte bit counter (counts 0..8)
// The TX/TX_ACK states are only reachable when I2C_TGT_READ_EN is defined.
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEF = 7'h21;
    localparam int         BYTE_W       = 8;
    localparam int         BITCNT_W     = 4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_REG      = 4'd3,
        ST_REG_ACK  = 4'd4,
        ST_DATA     = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_IGNORE   = 4'd7,
        ST_TX       = 4'd8,
        ST_TX_ACK   = 4'd9
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Synchronises the asynchronous SCL/SDA pins into the clk domain and derives
// single-cycle bus events.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   scl_in, sda_in      : raw pin levels (asynchronous)
//   scl_rise, scl_fall  : one-cycle pulses on synchronised SCL edges
//   start_det, stop_det : one-cycle START / STOP conditions
//   sda_s               : synchronised SDA level
// ----------------------------------------------------------------------------
module i2c_line_sync #(
    parameter int GLITCH_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [GLITCH_CYC-1:0] r_scl_sync;
    logic [GLITCH_CYC-1:0] r_sda_sync;
    logic                  r_scl_d;
    logic                  r_sda_d;
    logic                  w_scl_s;
    logic                  w_sda_s;

    // An idle bus is pulled high, so the chains reset to 1 to avoid
    // fabricating an edge when reset is released on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[GLITCH_CYC-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[GLITCH_CYC-2:0], sda_in};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s = r_scl_sync[GLITCH_CYC-1];
    assign w_sda_s = r_sda_sync[GLITCH_CYC-1];

    assign scl_rise = w_scl_s & ~r_scl_d;
    assign scl_fall = ~w_scl_s & r_scl_d;

    // SDA transitions only count as START/STOP while SCL has been high for
    // both the current and previous sample; if SCL moves in the same cycle
    // the SCL edge wins and the SDA change is treated as ordinary data.
    assign start_det = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign stop_det  = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
    assign sda_s     = w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// ----------------------------------------------------------------------------
// i2c_target
// I2C register-write target. Matches DEV_ADDR, ACKs, and turns
// "dev-addr(W), reg-addr, data, data, ..." into one-cycle write strobes with
// an auto-incrementing register pointer.
// Optional feature macro: I2C_TGT_READ_EN (adds register reads, R/W=1).
// Ports:
//   clk, i2c_reset_n   : system clock, asynchronous active-low reset
//   scl_in, sda_in     : bus pin levels (asynchronous)
//   sda_oe             : 1 = pull SDA low
//   wr_en/addr/data    : register-write strobe and its payload
//   busy               : addressed transaction in progress (until STOP)
//   o_dbg_state        : current FSM state, for observation only
//   rd_addr, rd_data   : register read port (I2C_TGT_READ_EN only)
// Handshake: wr_en is a one-cycle strobe with no back-pressure; wr_addr and
// wr_data are valid in that cycle and hold until the next strobe.
// ----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEF,
    parameter int         GLITCH_CYC = 2
) (
    input  logic        clk,
    input  logic        i2c_reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output state_t      o_dbg_state,
    output logic        busy
`ifdef I2C_TGT_READ_EN
    ,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data
`endif
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    i2c_line_sync #(.GLITCH_CYC(GLITCH_CYC)) u_line_sync (
        .clk       (clk),
        .rst_n     (i2c_reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    state_t                r_state, w_state;
    logic [BITCNT_W-1:0]   r_bit_cnt, w_bit_cnt;
    logic [BYTE_W-1:0]     r_shift, w_shift;
    logic [BYTE_W-1:0]     r_ptr, w_ptr;
    logic                  r_sda_oe, w_sda_oe;
    logic                  r_wr_en, w_wr_en;
    logic [BYTE_W-1:0]     r_wr_addr, w_wr_addr;
    logic [BYTE_W-1:0]     r_wr_data, w_wr_data;
    logic                  r_busy, w_busy;
`ifdef I2C_TGT_READ_EN
    logic                  r_read, w_read;
    logic [BYTE_W-1:0]     r_tx, w_tx;
`endif

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
`ifdef I2C_TGT_READ_EN
            r_read    <= 1'b0;
            r_tx      <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_ptr     <= w_ptr;
            r_sda_oe  <= w_sda_oe;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_busy    <= w_busy;
`ifdef I2C_TGT_READ_EN
            r_read    <= w_read;
            r_tx      <= w_tx;
`endif
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_ptr     = r_ptr;
        w_sda_oe  = r_sda_oe;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_busy    = r_busy;
`ifdef I2C_TGT_READ_EN
        w_read    = r_read;
        w_tx      = r_tx;
`endif

        case (r_state)
            ST_ADDR, ST_REG, ST_DATA: begin
                if (w_scl_rise) begin
                    w_shift   = {r_shift[BYTE_W-2:0], w_sda_s};
                    w_bit_cnt = r_bit_cnt + 4'd1;
                end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                    // Byte complete: every accepted byte is ACKed from here.
                    w_bit_cnt = '0;
                    w_sda_oe  = 1'b1;
                    if (r_state == ST_ADDR) begin
                        if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
                            w_state = ST_ADDR_ACK;
                            w_busy  = 1'b1;
`ifdef I2C_TGT_READ_EN
                            w_read  = 1'b0;
                        end else if (r_shift[7:1] == DEV_ADDR) begin
                            w_state = ST_ADDR_ACK;
                            w_busy  = 1'b1;
                            w_read  = 1'b1;
`endif
                        end else begin
                            w_state  = ST_IGNORE;
                            w_sda_oe = 1'b0;
                        end
                    end else if (r_state == ST_REG) begin
                        w_ptr   = r_shift;
                        w_state = ST_REG_ACK;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_ptr;
                        w_wr_data = r_shift;
                        w_ptr     = r_ptr + 8'd1;
                        w_state   = ST_DATA_ACK;
                    end
                end
            end

            // The first SCL fall seen in an ACK state ends the 9th clock.
            ST_ADDR_ACK: begin
                if (w_scl_fall) begin
                    w_sda_oe = 1'b0;
                    w_state  = ST_REG;
`ifdef I2C_TGT_READ_EN
                    if (r_read) begin
                        w_tx      = rd_data;
                        w_sda_oe  = ~rd_data[7];
                        w_bit_cnt = '0;
                        w_state   = ST_TX;
                    end
`endif
                end
            end

            ST_REG_ACK, ST_DATA_ACK: begin
                if (w_scl_fall) begin
                    w_sda_oe = 1'b0;
                    w_state  = ST_DATA;
                end
            end

`ifdef I2C_TGT_READ_EN
            // The current bit sits in r_tx[7]; the next one is put on the
            // bus after each falling edge until all 8 have been clocked.
            ST_TX: begin
                if (w_scl_rise) begin
                    w_bit_cnt = r_bit_cnt + 4'd1;
                end else if (w_scl_fall) begin
                    if (r_bit_cnt == 4'd8) begin
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = '0;
                        w_state   = ST_TX_ACK;
                    end else begin
                        w_tx     = {r_tx[BYTE_W-2:0], 1'b0};
                        w_sda_oe = ~r_tx[6];
                    end
                end
            end

            // The pointer advances on the ACK rising edge so rd_data for the
            // next byte has settled by the following falling edge.
            ST_TX_ACK: begin
                if (w_scl_rise) begin
                    if (!w_sda_s) begin
                        w_ptr = r_ptr + 8'd1;
                    end else begin
                        w_state = ST_IGNORE;
                    end
                end else if (w_scl_fall) begin
                    w_tx      = rd_data;
                    w_sda_oe  = ~rd_data[7];
                    w_bit_cnt = '0;
                    w_state   = ST_TX;
                end
            end
`endif

            default: begin
            end
        endcase

        // Bus conditions override whatever the current state decided.
        if (w_stop) begin
            w_state   = ST_IDLE;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
            w_bit_cnt = '0;
        end else if (w_start) begin
            w_state   = ST_ADDR;
            w_sda_oe  = 1'b0;
            w_bit_cnt = '0;
        end
    end

    assign sda_oe      = r_sda_oe;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;
`ifdef I2C_TGT_READ_EN
    assign rd_addr     = r_ptr;
`endif

endmodule

// File: tb/tb_i2c_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_target
// Directed bench for i2c_target: a bus master model drives SCL/SDA, the
// target's open-drain pull is wired-ANDed onto SDA, and every register write
// is checked against an expected queue.
// ----------------------------------------------------------------------------
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;  // quarter SCL period in clk cycles (SCL = clk/40)

    logic        clk = 1'b0;
    logic        i2c_reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    state_t      dbg_state;
`ifdef I2C_TGT_READ_EN
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  rd_mem [256];
    assign rd_data = rd_mem[rd_addr];
`endif

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    i2c_target dut (
        .clk         (clk),
        .i2c_reset_n (i2c_reset_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .o_dbg_state (dbg_state),
        .busy        (busy)
`ifdef I2C_TGT_READ_EN
        ,
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe pops the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (i2c_reset_n && wr_en) begin
            logic [15:0] exp_v;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            check("wr_strobe", {16'h0, wr_addr, wr_data}, {16'h0, exp_v});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // Sends a byte, then clocks the 9th bit with SDA released and checks the
    // target's pull against exp_ack in the middle of SCL high.
    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check(tag, {31'h0, sda_oe}, {31'h0, exp_ack});
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // ---------------- stimulus ----------------
    initial begin
`ifdef I2C_TGT_READ_EN
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i);
        rd_mem[8'h10] = 8'hA5;
`endif
        tick(3);
        check("rst_sda_oe",  {31'h0, sda_oe}, 32'h0);
        check("rst_wr_en",   {31'h0, wr_en},  32'h0);
        check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_busy",    {31'h0, busy},   32'h0);
        check("rst_state",   {28'h0, dbg_state}, {28'h0, ST_IDLE});
`ifdef I2C_TGT_READ_EN
        check("rst_rd_addr", {24'h0, rd_addr}, 32'h0);
`endif
        i2c_reset_n = 1'b1;
        tick(5);

        // Basic write 0x12 <- 0x80
        i2c_start();
        write_byte(8'h42, 1'b1, "t1_addr_ack");
        check("t1_busy_hi", {31'h0, busy}, 32'h1);
        write_byte(8'h12, 1'b1, "t1_reg_ack");
        exp_q.push_back({8'h12, 8'h80});
        write_byte(8'h80, 1'b1, "t1_data_ack");
        i2c_stop();
        check("t1_busy_lo", {31'h0, busy}, 32'h0);
        check("t1_hold_addr", {24'h0, wr_addr}, 32'h12);
        check("t1_hold_data", {24'h0, wr_data}, 32'h80);

        // Wrong address: no ACK, ignored until STOP
        i2c_start();
        write_byte(8'h44, 1'b0, "t2_addr_nack");
        check("t2_state_ign", {28'h0, dbg_state}, {28'h0, ST_IGNORE});
        check("t2_busy_lo", {31'h0, busy}, 32'h0);
        write_byte(8'h55, 1'b0, "t2_byte_nack");
        i2c_stop();
        check("t2_state_idle", {28'h0, dbg_state}, {28'h0, ST_IDLE});

`ifndef I2C_TGT_READ_EN
        // Matching address with R/W=1 is not supported without reads
        i2c_start();
        write_byte(8'h43, 1'b0, "t2b_read_nack");
        i2c_stop();
`endif

        // Next valid transaction after the rejected one
        i2c_start();
        write_byte(8'h42, 1'b1, "t3_addr_ack");
        write_byte(8'h20, 1'b1, "t3_reg_ack");
        exp_q.push_back({8'h20, 8'h5C});
        write_byte(8'h5C, 1'b1, "t3_data_ack");
        i2c_stop();

        // Pointer wrap 0xFE, 0xFF, 0x00
        i2c_start();
        write_byte(8'h42, 1'b1, "t4_addr_ack");
        write_byte(8'hFE, 1'b1, "t4_reg_ack");
        exp_q.push_back({8'hFE, 8'h11});
        write_byte(8'h11, 1'b1, "t4_d0_ack");
        exp_q.push_back({8'hFF, 8'h22});
        write_byte(8'h22, 1'b1, "t4_d1_ack");
        exp_q.push_back({8'h00, 8'h33});
        write_byte(8'h33, 1'b1, "t4_d2_ack");
        i2c_stop();

        // Reset in the middle of the register byte
        i2c_start();
        write_byte(8'h42, 1'b1, "t5_addr_ack");
        send_bit(1'b0);
        send_bit(1'b1);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        i2c_reset_n = 1'b0;
        #1;
        check("t5_rst_oe",   {31'h0, sda_oe}, 32'h0);
        check("t5_rst_busy", {31'h0, busy},   32'h0);
        check("t5_rst_addr", {24'h0, wr_addr}, 32'h0);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(5);
        i2c_reset_n = 1'b1;
        tick(5);
        i2c_start();
        write_byte(8'h42, 1'b1, "t5_addr2_ack");
        write_byte(8'h05, 1'b1, "t5_reg2_ack");
        exp_q.push_back({8'h05, 8'hAA});
        write_byte(8'hAA, 1'b1, "t5_data2_ack");
        i2c_stop();

        // Repeated START after the register byte
        i2c_start();
        write_byte(8'h42, 1'b1, "t6_addr_ack");
        write_byte(8'h77, 1'b1, "t6_reg_ack");
        i2c_start();
        check("t6_busy_hold", {31'h0, busy}, 32'h1);
        write_byte(8'h42, 1'b1, "t6_addr2_ack");
        write_byte(8'h30, 1'b1, "t6_reg2_ack");
        exp_q.push_back({8'h30, 8'h5A});
        write_byte(8'h5A, 1'b1, "t6_data_ack");
        i2c_stop();

`ifdef I2C_TGT_READ_EN
        // Register read: 0x42, 0x10, Sr, 0x43, read 0xA5, master NACK
        begin
            logic [7:0] rx;
            rx = '0;
            i2c_start();
            write_byte(8'h42, 1'b1, "t7_addr_ack");
            write_byte(8'h10, 1'b1, "t7_reg_ack");
            i2c_start();
            write_byte(8'h43, 1'b1, "t7_raddr_ack");
            for (int i = 7; i >= 0; i--) begin
                sda_m = 1'b1; tick(Q);
                scl_m = 1'b1; tick(Q);
                rx[i] = sda_in;
                tick(Q);
                scl_m = 1'b0; tick(Q);
            end
            check("t7_rd_byte", {24'h0, rx}, 32'hA5);
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            check("t7_released", {31'h0, sda_oe}, 32'h0);
            tick(Q);
            scl_m = 1'b0; tick(Q);
            check("t7_ignore", {28'h0, dbg_state}, {28'h0, ST_IGNORE});
            i2c_stop();
        end
`endif

        tick(20);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Register-write I2C target (responder) for the camera configuration bus. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address, ACKs, and turns each "device-address, register-address, data…" write into a one-cycle register-write strobe. Serves as the on-chip stand-in for the sensor's SCCB/I2C port, so the 100 kHz configuration master can be closed-loop tested and reused for board-side register banks.

## Interface
Parameters:
- DEV_ADDR, 7'h21, 7-bit target address (write byte 8'h42).
- GLITCH_CYC, 2, pipeline depth of the SCL/SDA synchronisers, minimum 2.

Ports:
- clk  in  1  system clock, at least 20× SCL rate (100 MHz nominal).
- i2c_reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- wr_en  out  1  one-cycle register-write strobe.
- wr_addr  out  8  register address for wr_en.
- wr_data  out  8  register data for wr_en.
- busy  out  1  high from an addressed START until STOP.
- rd_addr  out  8  register read address (only with I2C_TGT_READ_EN).
- rd_data  in  8  register read data, sampled combinationally (only with I2C_TGT_READ_EN).

## Operation
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, rd_addr=0; state IDLE; bit counter 0.
- scl/sda each pass GLITCH_CYC sync flops, then one history flop for edge detect.
- START: synced SDA falls while synced SCL high. STOP: SDA rises while SCL high. Both take effect in any state; STOP → IDLE, sda_oe=0, busy=0; START (incl. repeated) → ADDR, bit counter cleared.
- Data bits are sampled on synced SCL rising edge, MSB first; a byte completes on the SCL falling edge after the 8th rising edge.
- States: IDLE → ADDR (START) → ADDR_ACK → REG → REG_ACK → DATA ⇄ DATA_ACK; IGNORE (wait for START/STOP).
- ADDR: byte[7:1] == DEV_ADDR and byte[0]==0 → ADDR_ACK, busy=1. Mismatch → IGNORE, sda_oe stays 0.
- *_ACK: sda_oe=1 from the falling edge ending bit 8 until the falling edge ending the 9th clock, then release and move to next state.
- REG byte loads the internal register pointer.
- Each DATA byte: wr_en pulses with wr_addr=pointer, wr_data=byte, in the same cycle sda_oe rises; pointer then increments mod 256 (0xFF → 0x00).
- wr_addr/wr_data hold their last values between strobes.
- Master NACK is not applicable in write mode; target always ACKs addressed bytes.

## Timing
- Pin edge → internal event: GLITCH_CYC+1 clk cycles (3 at default).
- sda_oe assert/release: 1 cycle after the internal SCL falling edge event.
- wr_en: exactly 1 cycle wide, never back-to-back faster than one byte time.
- START and STOP detected in the same internal cycle as an SCL edge are impossible by definition (require SCL high); SCL edge and SDA edge in the same cycle: SCL edge is processed, SDA change ignored as a data transition.
- Reset mid-transfer: outputs return to reset values immediately; next activity requires a fresh START.

## Configuration
- I2C_TGT_READ_EN defined: ADDR byte with R/W=1 and matching address → ADDR_ACK → TX. TX shifts rd_data (captured at ADDR_ACK exit from rd_addr=pointer) MSB first, sda_oe = ~bit, changes after SCL falling edge. After 8 bits, release SDA and sample master ACK on 9th rising edge: ACK → pointer+1, reload, continue; NACK → IGNORE. rd_addr ports exist.
- Undefined: R/W=1 treated as mismatch (no ACK, IGNORE); rd_addr/rd_data ports absent.

## Structure
- Package i2c_pkg: state enum, DEV_ADDR default 7'h21, byte/bit-count widths.
- Sub-module i2c_line_sync: synchroniser + edge/START/STOP detection for SCL and SDA, outputs single-cycle scl_rise, scl_fall, start_det, stop_det, sda_s.

## Test plan
- Write 0x42, 0x12, 0x80, STOP at 100 kHz → ACK low on all three 9th clocks; one wr_en with wr_addr=0x12, wr_data=0x80; busy falls after STOP.
- Address 0x44 → no ACK (sda_oe stays 0 through 9th clock), no wr_en, next valid transaction accepted.
- 0x42, 0xFE, 0x11, 0x22, 0x33 → wr_en at 0xFE=0x11, 0xFF=0x22, 0x00=0x33.
- i2c_reset_n low during REG byte → sda_oe=0, busy=0 immediately; subsequent 0x42,0x05,0xAA write yields wr_addr=0x05, wr_data=0xAA.
- Repeated START after REG byte, then 0x42, 0x30, 0x5A → wr_en at 0x30=0x5A only.
- With I2C_TGT_READ_EN: 0x42,0x10, Sr, 0x43, rd_data=0xA5 → target ACKs, shifts 10100101 on SDA, releases for master NACK, then IGNORE.
